// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - opcode / funct constants for the supported instruction subset
//   - memSize encodings
//   - FSM state enum and instruction-class enum
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LL    = 6'b110000;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef enum logic [3:0] {
    RTYPE,
    JR,
    IALU,
    LOAD,
    STORE,
    BRANCH,
    JUMP,
    JAL,
    ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
//   instr    : latched instruction word
//   cls      : instruction class
//   reg_dest : 1 = destination from rd field, 0 = rt field / link register
//   rd       : destination register address (0 for non-writing classes)
//   mem_size : access size for loads/stores (word otherwise)
module mc_decode
  import mc_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input  logic [31:0]           instr,
  output instr_class_t          cls,
  output logic                  reg_dest,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [1:0]            mem_size
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  // rs and shamt are datapath concerns only
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    cls      = ILLEGAL;
    reg_dest = 1'b0;
    rd       = '0;
    mem_size = MEM_SIZE_WORD;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          cls = JR;
        end else begin
          cls      = RTYPE;
          reg_dest = 1'b1;
          rd       = REG_ADDR_W'(instr[15:11]);
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        cls = IALU;
        rd  = REG_ADDR_W'(instr[20:16]);
      end
      OP_LW, OP_LL: begin
        cls = LOAD;
        rd  = REG_ADDR_W'(instr[20:16]);
      end
      OP_LHU: begin
        cls      = LOAD;
        rd       = REG_ADDR_W'(instr[20:16]);
        mem_size = MEM_SIZE_HALF;
      end
      OP_LBU: begin
        cls      = LOAD;
        rd       = REG_ADDR_W'(instr[20:16]);
        mem_size = MEM_SIZE_BYTE;
      end
      OP_SW: cls = STORE;
      OP_SH: begin
        cls      = STORE;
        mem_size = MEM_SIZE_HALF;
      end
      OP_SB: begin
        cls      = STORE;
        mem_size = MEM_SIZE_BYTE;
      end
      OP_BEQ, OP_BNE: cls = BRANCH;
      OP_J:           cls = JUMP;
      OP_JAL: begin
        cls = JAL;
        rd  = REG_ADDR_W'(LINK_REG);
      end
      default: cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit.
// Accepts one instruction in IDLE via instr_valid/instr_ready, then sequences
// register-file and data-memory strobes; MEM waits are bounded by MEM_TIMEOUT.
//   clk, rst               : clock, async active-high reset
//   instr_valid/ready      : instruction handshake (ready only in IDLE)
//   instruction            : instruction word
//   mem_ack                : data memory completion (sampled in MEM only)
//   regWr, regDest, rd     : register-file write strobe / destination select / address
//   memRead, memWr, memSize: data-memory request strobes and access size
//   done, illegal, mem_err : retire / unsupported opcode / memory timeout pulses
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// DECODE | classify latched instruction, update regDest/rd
// EXEC   | execute; no-write non-memory instructions retire here
// MEM    | memory request held until ack or timeout
// WB     | one-cycle register write, retire
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int LINK_REG    = 31,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instruction,
  input  logic                  mem_ack,
  output logic                  regWr,
  output logic                  regDest,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  memRead,
  output logic                  memWr,
  output logic [1:0]            memSize,
  output logic                  done,
  output logic                  illegal,
  output logic                  mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t                  state_q, state_d;
  instr_class_t            cls_q, cls_d;
  logic [31:0]             instr_q, instr_d;
  logic [1:0]              size_q, size_d;
  logic                    reg_dest_q, reg_dest_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  instr_class_t            dec_cls;
  logic                    dec_reg_dest;
  logic [REG_ADDR_W-1:0]   dec_rd;
  logic [1:0]              dec_size;

  mc_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .LINK_REG   (LINK_REG)
  ) u_decode (
    .instr    (instr_q),
    .cls      (dec_cls),
    .reg_dest (dec_reg_dest),
    .rd       (dec_rd),
    .mem_size (dec_size)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cls_q      <= ILLEGAL;
      instr_q    <= '0;
      size_q     <= MEM_SIZE_WORD;
      reg_dest_q <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      instr_q    <= instr_d;
      size_q     <= size_d;
      reg_dest_q <= reg_dest_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  // ready is held low while reset is asserted so every output reads 0 then
  assign instr_ready = (state_q == IDLE) && !rst;

  // regDest/rd become visible in the DECODE cycle itself, then hold from the flops
  assign regDest = (state_q == DECODE) ? dec_reg_dest : reg_dest_q;
  assign rd      = (state_q == DECODE) ? dec_rd       : rd_q;

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    instr_d    = instr_q;
    size_d     = size_q;
    reg_dest_d = reg_dest_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    regWr      = 1'b0;
    memRead    = 1'b0;
    memWr      = 1'b0;
    memSize    = MEM_SIZE_WORD;
    done       = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instruction;
          state_d = DECODE;
        end
      end
      DECODE: begin
        cls_d      = dec_cls;
        size_d     = dec_size;
        reg_dest_d = dec_reg_dest;
        rd_d       = dec_rd;
        if (dec_cls == ILLEGAL) begin
          illegal = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (cls_q)
          RTYPE, IALU, JAL: state_d = WB;
          LOAD, STORE: begin
            cnt_d   = '0;
            state_d = MEM;
          end
          default: begin
            done    = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      MEM: begin
        memRead = (cls_q == LOAD);
        memWr   = (cls_q == STORE);
        memSize = size_q;
        // ack is checked first so it wins over a simultaneous timeout
        if (mem_ack) begin
          cnt_d = '0;
          if (cls_q == LOAD) begin
            state_d = WB;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          mem_err = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        regWr   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

  localparam int T    = 15;
  localparam int LINK = 31;

  typedef enum {K_R, K_JR, K_IALU, K_LOAD, K_STORE, K_NOWR, K_JAL, K_ILL} kind_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        mem_ack;
  logic        regWr, regDest, memRead, memWr, done, illegal, mem_err;
  logic [4:0]  rd;
  logic [1:0]  memSize;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_control_unit #(
    .REG_ADDR_W  (5),
    .LINK_REG    (LINK),
    .MEM_TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .mem_ack     (mem_ack),
    .regWr       (regWr),
    .regDest     (regDest),
    .rd          (rd),
    .memRead     (memRead),
    .memWr       (memWr),
    .memSize     (memSize),
    .done        (done),
    .illegal     (illegal),
    .mem_err     (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic kind_t kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'b000000: return (ins[5:0] == 6'b001000) ? K_JR : K_R;
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: return K_IALU;
      6'b100011, 6'b100101, 6'b100100, 6'b110000: return K_LOAD;
      6'b101011, 6'b101001, 6'b101000:            return K_STORE;
      6'b000100, 6'b000101, 6'b000010:            return K_NOWR;
      6'b000011:                                  return K_JAL;
      default:                                    return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] size_of(input logic [5:0] op);
    case (op)
      6'b100101, 6'b101001: return 2'b01;
      6'b100100, 6'b101000: return 2'b10;
      default:              return 2'b00;
    endcase
  endfunction

  // {instr_ready, regWr, memRead, memWr, done, illegal, mem_err}
  function automatic logic [6:0] strobes();
    return {instr_ready, regWr, memRead, memWr, done, illegal, mem_err};
  endfunction

  // ack_k: MEM cycle (1-based) in which mem_ack is raised; outside 1..T means never
  task automatic run(input logic [31:0] ins, input int ack_k);
    kind_t      k;
    int         m, last, mem_lo, mem_hi, wr_cyc, done_cyc, err_cyc, ill_cyc;
    bit         acked, writes, is_mem;
    logic [4:0] exp_rd;
    logic [6:0] exp;

    k        = kind_of(ins);
    acked    = (ack_k >= 1) && (ack_k <= T);
    m        = acked ? ack_k : T;
    is_mem   = (k == K_LOAD) || (k == K_STORE);
    writes   = (k == K_R) || (k == K_IALU) || (k == K_JAL) || (k == K_LOAD);
    exp_rd   = (k == K_R) ? ins[15:11] : (k == K_JAL) ? 5'(LINK) : ins[20:16];
    mem_lo   = -1; mem_hi = -1; wr_cyc = -1; done_cyc = -1; err_cyc = -1; ill_cyc = -1;

    case (k)
      K_ILL: begin ill_cyc = 1; last = 2; end
      K_JR, K_NOWR: begin done_cyc = 2; last = 3; end
      K_R, K_IALU, K_JAL: begin wr_cyc = 3; done_cyc = 3; last = 4; end
      default: begin
        mem_lo = 3;
        mem_hi = 2 + m;
        if (!acked) begin
          err_cyc = 2 + m; last = 3 + m;
        end else if (k == K_LOAD) begin
          wr_cyc = 3 + m; done_cyc = 3 + m; last = 4 + m;
        end else begin
          done_cyc = 2 + m; last = 3 + m;
        end
      end
    endcase

    instr_valid = 1'b1;
    instruction = ins;
    mem_ack     = 1'($urandom);
    @(negedge clk);
    chk("accept_ready", 32'(strobes()), 32'b1000000);
    @(posedge clk); #1;

    for (int c = 1; c < last; c++) begin
      instr_valid = 1'($urandom);
      instruction = $urandom;
      if (is_mem && c >= mem_lo && c <= mem_hi)
        mem_ack = acked && (c == mem_hi);
      else
        mem_ack = 1'($urandom);
      @(negedge clk);
      exp = '0;
      exp[5] = (c == wr_cyc);
      exp[4] = (k == K_LOAD)  && (c >= mem_lo) && (c <= mem_hi);
      exp[3] = (k == K_STORE) && (c >= mem_lo) && (c <= mem_hi);
      exp[2] = (c == done_cyc);
      exp[1] = (c == ill_cyc);
      exp[0] = (c == err_cyc);
      chk($sformatf("strobes_op%0h_c%0d", ins[31:26], c), 32'(strobes()), 32'(exp));
      if (writes) begin
        chk("rd", 32'(rd), 32'(exp_rd));
        chk("regDest", 32'(regDest), 32'(k == K_R));
      end
      if (is_mem && c >= mem_lo && c <= mem_hi)
        chk("memSize", 32'(memSize), 32'(size_of(ins[31:26])));
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] legal [20];
    logic [31:0] w;
    legal = '{6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100,
              6'b001101, 6'b001110, 6'b001111, 6'b100011, 6'b100101,
              6'b100100, 6'b110000, 6'b101011, 6'b101001, 6'b101000,
              6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b000000};
    w = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        w[31:26] = 6'b000000;
        w[5:0]   = 6'b001000;
      end
      1: begin
        for (int t = 0; t < 64; t++) begin
          w[31:26] = 6'($urandom);
          if (kind_of(w) == K_ILL) break;
        end
      end
      default: w[31:26] = legal[$urandom_range(0, 19)];
    endcase
    return w;
  endfunction

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    mem_ack     = 1'b0;
    #1;
    chk("in_reset_outputs",
        32'({instr_ready, regWr, regDest, rd, memRead, memWr, memSize, done, illegal, mem_err}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs",
        32'({instr_ready, regWr, regDest, rd, memRead, memWr, memSize, done, illegal, mem_err}), 32'h4000);
    @(posedge clk); #1;

    run(32'h00221820, 0);   // add $3,$1,$2
    run(32'h8C250004, 3);   // lw $5,4($1), ack on 3rd MEM cycle
    run(32'hA0470000, 1);   // sb $7,0($2), ack on MEM entry
    run(32'h0C000010, 0);   // jal
    run(32'h03E00008, 0);   // jr $31
    run(32'h8C250004, 0);   // lw, never acked -> timeout
    run(32'hAC250004, T);   // sw, ack on the last allowed MEM cycle
    run(32'hFC000000, 0);   // unsupported opcode

    // reset while a load is waiting in MEM
    instr_valid = 1'b1;
    instruction = 32'h8C250004;
    mem_ack     = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_mem_memRead", 32'(memRead), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_mem_reset_outputs",
        32'({instr_ready, regWr, regDest, rd, memRead, memWr, memSize, done, illegal, mem_err}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_mid_reset",
        32'({instr_ready, regWr, regDest, rd, memRead, memWr, memSize, done, illegal, mem_err}), 32'h4000);
    @(posedge clk); #1;

    for (int i = 0; i < 250; i++)
      run(rand_instr(), $urandom_range(0, T + 2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle successor to the single-cycle MIPS control unit. It accepts one instruction at a time through a valid/ready handshake and latches it. It steps the instruction through IDLE/DECODE/EXEC/MEM/WB states and sequences regWr, memRead and memWr as timed strobes; the destination register and regDest are held as levels. It sits between the instruction fetch stage and the register file/data memory, and adds a bounded memory-wait timeout.

Parameters:
REG_ADDR_W, 5, width of register-address fields and of rd output
LINK_REG, 31, destination register written by jal
MEM_TIMEOUT, 15, max cycles spent in MEM waiting for mem_ack before abort (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction word offered
instr_ready  out  1  unit can accept; high only in IDLE
instruction  in  32  instruction word; opcode [31:26], rt [20:16], rd [15:11], funct [5:0]
mem_ack  in  1  data memory completed current access
regWr  out  1  register-file write strobe, one cycle in WB
regDest  out  1  1 = rd field, 0 = rt field / link register
rd  out  REG_ADDR_W  destination register address
memRead  out  1  load request, held in MEM until ack/timeout
memWr  out  1  store request, held in MEM until ack/timeout
memSize  out  2  00 word, 01 half, 10 byte; valid while memRead/memWr high
done  out  1  one-cycle pulse when an instruction retires
illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode
mem_err  out  1  one-cycle pulse on MEM timeout

Behaviour:
- Reset (async):
  - state=IDLE, all outputs 0, instr_ready=1 after release, timeout counter 0, latched instruction cleared.
  - Reset mid-operation drops any pending access with no WB.
- Accept:
  - Handshake completes in IDLE when instr_valid && instr_ready.
  - Instruction is latched; next state DECODE. instr_valid outside IDLE is ignored.
- DECODE (1 cycle):
  - Classify the instruction.
  - Set regDest and rd; these hold until the next accept.
  - Unknown opcode: illegal=1, go to IDLE, no done.
- Classes and paths (cycle 0 = accept):
  - R-type (op 000000), funct != 001000: regDest=1, rd=instr[15:11]. Path DECODE, EXEC, WB. regWr at cycle 3, done at cycle 3.
  - jr (funct 001000): no write. Path DECODE, EXEC, IDLE. done at cycle 2.
  - I-type ALU (addi 001000, addiu 001001, andi 001100, ori 001101, xori 001110, slti 001010, sltiu 001011, lui 001111): regDest=0, rd=instr[20:16]. Timing as R-type.
  - Loads (lw 100011 word, lhu 100101 half, lbu 100100 byte, ll 110000 word): rd=rt. Path EXEC, MEM, WB.
  - Stores (sw 101011, sh 101001, sb 101000): no write. Path EXEC, MEM, IDLE.
  - beq 000100, bne 000101, j 000010: no write. Path DECODE, EXEC, IDLE.
  - jal 000011: regDest=0, rd=LINK_REG. Path DECODE, EXEC, WB.
- MEM:
  - memRead/memWr asserted from the cycle MEM is entered until the cycle mem_ack is sampled high, inclusive.
  - mem_ack in the first MEM cycle counts, giving a 1-cycle MEM.
  - On ack: load goes to WB; store pulses done and goes to IDLE.
  - Timeout counter increments each MEM cycle without ack. Reaching MEM_TIMEOUT gives mem_err=1, strobes drop, state IDLE, no WB, no done.
  - Ack and timeout in the same cycle: ack wins.
  - mem_ack outside MEM is ignored.
- WB: regWr=1 for exactly one cycle, done=1 in the same cycle; then IDLE.
- Register $0: a write to rd=0 is still strobed; suppression is the register file's job.
- No back-to-back accept: minimum interval between accepts is path length + 1.

Decomposition:
- Shared package mc_ctrl_pkg:
  - opcode and funct constants
  - memSize encodings
  - state enum (IDLE, DECODE, EXEC, MEM, WB)
  - instruction-class enum (RTYPE, JR, IALU, LOAD, STORE, BRANCH, JUMP, JAL, ILLEGAL)
- One combinational sub-module mc_decode: latched instruction in; class, regDest, rd, memSize out.

Test Plan:
- add $3,$1,$2 (0x00221820) accepted at cycle 0 -> regDest=1, rd=3; regWr and done pulse at cycle 3; instr_ready high at cycle 4.
- lw $5,4($1) (0x8C250004), mem_ack at 3rd MEM cycle -> memRead high 3 cycles, memSize=00, regWr once with rd=5, regDest=0.
- sb $7,0($2) (0xA0470000), mem_ack same cycle as MEM entry -> memWr 1 cycle, memSize=10, regWr never, done once.
- jal (0x0C000010) -> rd=31, regDest=0, regWr at cycle 3; jr $31 (0x03E00008) -> no regWr, done at cycle 2.
- lw with mem_ack never asserted, MEM_TIMEOUT=15 -> memRead high 15 cycles, mem_err pulse, no regWr, return to IDLE.
- Opcode 111111 -> illegal pulse at cycle 1, IDLE at cycle 2; separately, assert rst mid-MEM -> all outputs 0 immediately, instr_ready=1 after release.
